// File: rtl/complex_div_pkg.sv
// Shared widths, state encoding and Q8.8 saturation helper for the complex divider.
package complex_div_pkg;

  localparam int OP_W          = 8;            // operand width
  localparam int FRAC_BITS_DEF = 8;            // default fractional bits of the quotient
  localparam int Q_W           = 16;           // quotient width (Q8.8)
  localparam int DVD_W         = 25;           // divider dividend width: |num| << FRAC_BITS
  localparam int DEN_W         = 17;           // numerator / denominator width
  localparam int PROD_W        = 2 * OP_W;     // single multiplier product width

  // Q8.8 saturation limits
  localparam logic [Q_W-1:0]   Q_MAX     = 16'h7FFF;
  localparam logic [Q_W-1:0]   Q_MIN     = 16'h8000;
  localparam logic [DVD_W-1:0] POS_LIMIT = 25'd32767;
  localparam logic [DVD_W-1:0] NEG_LIMIT = 25'd32768;

  typedef enum logic [3:0] {
    IDLE,
    MUL0,
    MUL1,
    MUL2,
    MUL3,
    MUL4,
    MUL5,
    PREP,
    DIV_RE,
    DIV_IM,
    DONE
  } state_t;

  typedef struct packed {
    logic [Q_W-1:0] q;
    logic           sat;
  } qsat_t;

  // Apply the sign to a truncated magnitude and clamp to the signed 16-bit range.
  function automatic qsat_t saturate(input logic [DVD_W-1:0] mag, input logic neg);
    qsat_t r;
    if (neg) begin
      if (mag > NEG_LIMIT) begin
        r.q   = Q_MIN;
        r.sat = 1'b1;
      end else begin
        r.q   = Q_W'(DVD_W'(0) - mag);
        r.sat = 1'b0;
      end
    end else begin
      if (mag > POS_LIMIT) begin
        r.q   = Q_MAX;
        r.sat = 1'b1;
      end else begin
        r.q   = Q_W'(mag);
        r.sat = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/complex_divider_serial_divider.sv
// Restoring divider, one quotient bit per clock. The start cycle already performs
// the first step, and done is asserted during the cycle whose edge produces the
// last bit, with the finished quotient presented combinationally alongside it.
module serial_divider
  import complex_div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DEN_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient
);

  localparam logic [4:0] LAST = 5'(DVD_W - 1);

  logic [DEN_W-1:0] rem_q, rem_in, rem_nxt;
  logic [DVD_W-1:0] sh_q, sh_in, sh_nxt;
  logic [DEN_W:0]   partial, trial;
  logic [4:0]       cnt_q;
  logic             q_bit;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rem_nxt = '0;
    q_bit   = 1'b0;
    rem_in  = start ? '0 : rem_q;
    sh_in   = start ? dividend : sh_q;
    partial = {rem_in, sh_in[DVD_W-1]};
    trial   = partial - {1'b0, divisor};
    if (!trial[DEN_W]) begin
      rem_nxt = trial[DEN_W-1:0];
      q_bit   = 1'b1;
    end else begin
      rem_nxt = partial[DEN_W-1:0];
    end
    sh_nxt   = {sh_in[DVD_W-2:0], q_bit};
    done     = busy && (cnt_q == LAST);
    quotient = sh_nxt;
  end

  // Iteration state: remainder, dividend/quotient shift register and step count.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      busy  <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      sh_q  <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt_q <= 5'd1;
      rem_q <= rem_nxt;
      sh_q  <= sh_nxt;
    end else if (busy) begin
      rem_q <= rem_nxt;
      sh_q  <= sh_nxt;
      cnt_q <= cnt_q + 5'd1;
      if (cnt_q == LAST) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/complex_divider.sv
// Complex divider q = z / w in signed Q8.8: one shared 8x8 multiplier forms the six
// partial products, then one serial divider produces the real and imaginary parts.
module complex_divider
  import complex_div_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [7:0]     a1,
  input  logic [7:0]     b1,
  input  logic [7:0]     a2,
  input  logic [7:0]     b2,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [15:0]    q_re,
  output logic [15:0]    q_im,
  output logic           div_zero,
  output logic           sat
);

  state_t state_q, state_d;

  logic [OP_W-1:0]   a1_q, b1_q, a2_q, b2_q;
  logic [OP_W-1:0]   mul_x, mul_y;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] p_a1a2, p_b1b2, p_b1a2, p_a1b2, p_a2a2, p_b2b2;

  logic [DEN_W-1:0]        re_num, den, im_abs;
  logic signed [DEN_W-1:0] im_num;
  logic [DEN_W-1:0]        re_mag_q, im_mag_q, den_q, num_sel;
  logic                    im_neg_q;

  logic             div_start, div_busy, div_done;
  logic [DVD_W-1:0] div_dividend, div_quotient;
  qsat_t            div_res;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    div_start = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = MUL0;
      end
      MUL0: state_d = MUL1;
      MUL1: state_d = MUL2;
      MUL2: state_d = MUL3;
      MUL3: state_d = MUL4;
      MUL4: state_d = MUL5;
      MUL5: state_d = PREP;
      PREP: state_d = (den == '0) ? DONE : DIV_RE;
      DIV_RE: begin
        div_start = !div_busy;
        if (div_done) state_d = DIV_IM;
      end
      DIV_IM: begin
        div_start = !div_busy;
        if (div_done) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand routing for the single shared multiplier.
  always_comb begin
    mul_x = '0;
    mul_y = '0;
    case (state_q)
      MUL0: begin mul_x = a1_q; mul_y = a2_q; end
      MUL1: begin mul_x = b1_q; mul_y = b2_q; end
      MUL2: begin mul_x = b1_q; mul_y = a2_q; end
      MUL3: begin mul_x = a1_q; mul_y = b2_q; end
      MUL4: begin mul_x = a2_q; mul_y = a2_q; end
      MUL5: begin mul_x = b2_q; mul_y = b2_q; end
      default: ;
    endcase
  end

  assign prod = mul_x * mul_y;

  // Numerators and denominator from the stored products, plus divider operand selection.
  always_comb begin
    re_num       = {1'b0, p_a1a2} + {1'b0, p_b1b2};
    im_num       = $signed({1'b0, p_b1a2}) - $signed({1'b0, p_a1b2});
    den          = {1'b0, p_a2a2} + {1'b0, p_b2b2};
    im_abs       = im_num[DEN_W-1] ? DEN_W'(-im_num) : DEN_W'(im_num);
    num_sel      = (state_q == DIV_IM) ? im_mag_q : re_mag_q;
    div_dividend = DVD_W'(num_sel) << FRAC_BITS;
    div_res      = saturate(div_quotient, (state_q == DIV_IM) && im_neg_q);
  end

  serial_divider u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (den_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  // Datapath: operand capture, product storage, numerator prep and result registers.
  always_ff @(posedge clk) begin
    // NOTE: these are plain flops, not a memory array, so resetting all of them is cheap and keeps post-reset state clean.
    if (rst) begin
      a1_q     <= '0;
      b1_q     <= '0;
      a2_q     <= '0;
      b2_q     <= '0;
      p_a1a2   <= '0;
      p_b1b2   <= '0;
      p_b1a2   <= '0;
      p_a1b2   <= '0;
      p_a2a2   <= '0;
      p_b2b2   <= '0;
      re_mag_q <= '0;
      im_mag_q <= '0;
      im_neg_q <= 1'b0;
      den_q    <= '0;
      q_re     <= '0;
      q_im     <= '0;
      div_zero <= 1'b0;
      sat      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a1_q <= a1;
            b1_q <= b1;
            a2_q <= a2;
            b2_q <= b2;
          end
        end
        MUL0: p_a1a2 <= prod;
        MUL1: p_b1b2 <= prod;
        MUL2: p_b1a2 <= prod;
        MUL3: p_a1b2 <= prod;
        MUL4: p_a2a2 <= prod;
        MUL5: p_b2b2 <= prod;
        PREP: begin
          re_mag_q <= re_num;
          im_mag_q <= im_abs;
          im_neg_q <= im_num[DEN_W-1];
          den_q    <= den;
          div_zero <= (den == '0);
          sat      <= 1'b0;
          if (den == '0) begin
            q_re <= '0;
            q_im <= '0;
          end
        end
        DIV_RE: begin
          if (div_done) begin
            q_re <= div_res.q;
            sat  <= div_res.sat;
          end
        end
        DIV_IM: begin
          if (div_done) begin
            q_im <= div_res.q;
            sat  <= sat | div_res.sat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_divider.sv
// Scoreboard bench for complex_divider: the driver pushes expected results computed
// with plain integer arithmetic, and a monitor checks latency, hold stability and values.
module tb_complex_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a1, b1, a2, b2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] q_re, q_im;
  logic        div_zero;
  logic        sat;

  complex_divider #(.FRAC_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a1        (a1),
    .b1        (b1),
    .a2        (a2),
    .b2        (b2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q_re      (q_re),
    .q_im      (q_im),
    .div_zero  (div_zero),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q_re;
    logic [15:0] q_im;
    logic        dz;
    logic        sat;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   hold_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer: mostly ready, forced low during the hold test.
  always @(posedge clk) begin
    #1;
    out_ready = hold_mode ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic longint clamp(input longint v, inout bit s);
    if (v > 32767) begin s = 1'b1; return 32767; end
    if (v < -32768) begin s = 1'b1; return -32768; end
    return v;
  endfunction

  // Reference: exact complex quotient, scaled by 256, truncated toward zero.
  function automatic exp_t model(input int x1, input int y1, input int x2, input int y2);
    exp_t   e;
    longint re, im, den, qr, qi;
    bit     s;
    re  = x1 * x2 + y1 * y2;
    im  = y1 * x2 - x1 * y2;
    den = x2 * x2 + y2 * y2;
    s   = 1'b0;
    if (den == 0) begin
      e.q_re = 16'h0000;
      e.q_im = 16'h0000;
      e.dz   = 1'b1;
      e.sat  = 1'b0;
      e.lat  = 7;
    end else begin
      qr = (re * 256) / den;
      qi = ((im < 0 ? -im : im) * 256) / den;
      if (im < 0) qi = -qi;
      qr = clamp(qr, s);
      qi = clamp(qi, s);
      e.q_re = 16'(qr);
      e.q_im = 16'(qi);
      e.dz   = 1'b0;
      e.sat  = s;
      e.lat  = 57;
    end
    e.acc = 0;
    return e;
  endfunction

  task automatic send(input logic [7:0] x1, input logic [7:0] y1,
                      input logic [7:0] x2, input logic [7:0] y2);
    int   waited = 0;
    exp_t e;
    @(negedge clk);
    a1 = x1; b1 = y1; a2 = x2; b2 = y2;
    in_valid = 1'b1;
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e     = model(int'(x1), int'(y1), int'(x2), int'(y2));
    e.acc = cyc;
    exp_q.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (exp_q.size() != 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: latency on first out_valid, stability while held, values at handshake.
  logic        seen = 1'b0;
  logic [15:0] h_re, h_im;
  logic        h_dz, h_sat;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      seen = 1'b0;
    end else if (out_valid) begin
      check("in_ready_in_done", 32'(in_ready), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        if (!seen) begin
          seen  = 1'b1;
          h_re  = q_re;
          h_im  = q_im;
          h_dz  = div_zero;
          h_sat = sat;
          check("latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
        end else begin
          check("hold_q_re", 32'(q_re), 32'(h_re));
          check("hold_q_im", 32'(q_im), 32'(h_im));
          check("hold_flags", 32'({div_zero, sat}), 32'({h_dz, h_sat}));
        end
        if (out_ready) begin
          e = exp_q.pop_front();
          check("q_re", 32'(q_re), 32'(e.q_re));
          check("q_im", 32'(q_im), 32'(e.q_im));
          check("div_zero", 32'(div_zero), 32'(e.dz));
          check("sat", 32'(sat), 32'(e.sat));
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    int w;
    rst = 1'b1;
    in_valid = 1'b0;
    a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_q_re", 32'(q_re), 32'd0);
    check("rst_q_im", 32'(q_im), 32'd0);
    check("rst_div_zero", 32'(div_zero), 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed cases: worked example, unit ratio, zero divisor, saturation.
    send(8'd3, 8'd4, 8'd1, 8'd2);
    send(8'd10, 8'd0, 8'd10, 8'd0);
    send(8'd77, 8'd13, 8'd0, 8'd0);
    send(8'd255, 8'd255, 8'd1, 8'd0);
    send(8'd0, 8'd255, 8'd0, 8'd1);

    // Back-pressure: result held 10 cycles while new operands wait.
    wait_idle();
    hold_mode = 1'b1;
    send(8'd200, 8'd17, 8'd9, 8'd31);
    fork
      send(8'd5, 8'd250, 8'd3, 8'd7);
      begin
        w = 0;
        while (!out_valid && w < 200) begin
          @(negedge clk);
          w++;
        end
        if (!out_valid) check("hold_wait_timeout", 32'(out_valid), 32'd1);
        repeat (10) @(negedge clk);
        hold_mode = 1'b0;
      end
    join

    // Reset in the middle of an operation (sampled on edge N+20).
    wait_idle();
    send(8'd100, 8'd50, 8'd7, 8'd3);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_q_re", 32'(q_re), 32'd0);
    send(8'd9, 8'd8, 8'd7, 8'd6);

    // Randomized operands, occasionally with a zero divisor.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] r1, r2, r3, r4;
      r1 = 8'($urandom_range(0, 255));
      r2 = 8'($urandom_range(0, 255));
      r3 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      r4 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      send(r1, r2, r3, r4);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
